// File: rtl/pipeline_stage_write_back_pkg.sv
// Shared definitions for the write-back stage: register/data types and the forwarding record.
// The record type is the one the execution and decode hazard units already consume.
package pipeline_stage_write_back_pkg;

  localparam int WB_REG_COUNT    = 32;
  localparam int WB_DATA_WIDTH   = 32;
  localparam int WB_PC_WIDTH     = 32;
  localparam int WB_REG_ID_WIDTH = $clog2(WB_REG_COUNT);

  typedef logic [WB_REG_ID_WIDTH-1:0] register_id_t;
  typedef logic [WB_DATA_WIDTH-1:0]   int_t;

  localparam register_id_t ZERO_REGISTER = {WB_REG_ID_WIDTH{1'b0}};

  typedef struct packed {
    register_id_t registerId;
    logic         dataReady;
    int_t         data;
  } stage_register_data_t;

  // Record meaning "nothing in flight": consumers see r0, ready, zero data.
  function automatic stage_register_data_t emptyRecord();
    stage_register_data_t rec;
    rec.registerId = ZERO_REGISTER;
    rec.dataReady  = 1'b1;
    rec.data       = {WB_DATA_WIDTH{1'b0}};
    return rec;
  endfunction

endpackage

// File: rtl/pipeline_stage_write_back_register_file_2r1w.sv
// Architectural register file: one write port, two combinational read ports with
// same-cycle write-through, and register 0 hardwired to zero.
module register_file_2r1w
  import pipeline_stage_write_back_pkg::*;
#(
  parameter int REG_COUNT  = WB_REG_COUNT,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int ID_WIDTH   = $clog2(REG_COUNT)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ID_WIDTH-1:0]   writeId,
  input  logic [DATA_WIDTH-1:0] writeData,
  input  logic [ID_WIDTH-1:0]   readId1,
  input  logic [ID_WIDTH-1:0]   readId2,
  output logic [DATA_WIDTH-1:0] readData1,
  output logic [DATA_WIDTH-1:0] readData2
);

  logic [DATA_WIDTH-1:0] regs_r [REG_COUNT];
  logic                  writeAccepted_s;

  // A pending write wins over stored contents, except for register 0 which always reads zero.
  function automatic logic [DATA_WIDTH-1:0] bypassSelect(
    input logic [ID_WIDTH-1:0]   rid,
    input logic [DATA_WIDTH-1:0] stored,
    input logic                  we,
    input logic [ID_WIDTH-1:0]   wid,
    input logic [DATA_WIDTH-1:0] wdata
  );
    logic [DATA_WIDTH-1:0] result;
    if (rid == {ID_WIDTH{1'b0}}) begin
      result = {DATA_WIDTH{1'b0}};
    end else if (we && (rid == wid)) begin
      result = wdata;
    end else begin
      result = stored;
    end
    return result;
  endfunction

  assign writeAccepted_s = writeEnable && (writeId != {ID_WIDTH{1'b0}});

  // Storage update; register 0 is never written so it stays at its reset value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < REG_COUNT; i++) begin
        regs_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (writeAccepted_s) begin
      regs_r[writeId] <= writeData;
    end
  end

  // Combinational read ports with write-through.
  always_comb begin
    readData1 = bypassSelect(readId1, regs_r[readId1], writeAccepted_s, writeId, writeData);
    readData2 = bypassSelect(readId2, regs_r[readId2], writeAccepted_s, writeId, writeData);
  end

endmodule

// File: rtl/pipeline_stage_write_back.sv
// Write-back stage: retires memory-stage results, owns the register file and publishes the
// forwarding record. Optional retire/bubble counters under WRITE_BACK_RETIRE_COUNTER_EN.
module pipeline_stage_write_back
  import pipeline_stage_write_back_pkg::*;
#(
  parameter int REG_COUNT  = WB_REG_COUNT,
  parameter int DATA_WIDTH = WB_DATA_WIDTH,
  parameter int PC_WIDTH   = WB_PC_WIDTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         inBubble,
  input  logic [PC_WIDTH-1:0]          inProgramCounter,
  input  logic                         inRegWriteEnabled,
  input  logic [$clog2(REG_COUNT)-1:0] inRegWriteId,
  input  logic                         inRegDataWriteReady,
  input  logic [DATA_WIDTH-1:0]        inRegDataWrite,
  input  logic [$clog2(REG_COUNT)-1:0] readId1,
  input  logic [$clog2(REG_COUNT)-1:0] readId2,
  output logic [DATA_WIDTH-1:0]        readData1,
  output logic [DATA_WIDTH-1:0]        readData2,
  output stage_register_data_t         resultOfInstructionAfterWriteBack,
  output logic [PC_WIDTH-1:0]          retiredProgramCounter,
  output logic                         retireValid,
  output logic                         protocolError
`ifdef WRITE_BACK_RETIRE_COUNTER_EN
  ,
  output logic [63:0]                  retireCount,
  output logic [63:0]                  bubbleCount
`endif
);

  localparam int ID_WIDTH = $clog2(REG_COUNT);

  logic                  retire_s;
  logic                  writeCond_s;
  logic                  missingData_s;
  stage_register_data_t  recordNext_s;

  stage_register_data_t  record_r;
  logic [PC_WIDTH-1:0]   retiredPc_r;
  logic                  retireValid_r;
  logic                  protocolError_r;

  // Retire/write qualification; an r0 destination never counts as a write or as an error.
  always_comb begin
    retire_s      = !inBubble;
    writeCond_s   = 1'b0;
    missingData_s = 1'b0;
    if (retire_s && inRegWriteEnabled && (inRegWriteId != {ID_WIDTH{1'b0}})) begin
      writeCond_s   = inRegDataWriteReady;
      missingData_s = !inRegDataWriteReady;
    end else begin
      writeCond_s   = 1'b0;
      missingData_s = 1'b0;
    end
  end

  // Next forwarding record: only a real write publishes its id and data.
  always_comb begin
    recordNext_s = emptyRecord();
    if (writeCond_s) begin
      recordNext_s.registerId = inRegWriteId;
      recordNext_s.dataReady  = 1'b1;
      recordNext_s.data       = inRegDataWrite;
    end else begin
      recordNext_s = emptyRecord();
    end
  end

  register_file_2r1w #(
    .REG_COUNT  (REG_COUNT),
    .DATA_WIDTH (DATA_WIDTH),
    .ID_WIDTH   (ID_WIDTH)
  ) registerFile (
    .clock       (clock),
    .reset       (reset),
    .writeEnable (writeCond_s),
    .writeId     (inRegWriteId),
    .writeData   (inRegDataWrite),
    .readId1     (readId1),
    .readId2     (readId2),
    .readData1   (readData1),
    .readData2   (readData2)
  );

  // Retire bookkeeping, forwarding record and sticky protocol error.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      record_r        <= emptyRecord();
      retiredPc_r     <= {PC_WIDTH{1'b0}};
      retireValid_r   <= 1'b0;
      protocolError_r <= 1'b0;
    end else begin
      record_r        <= recordNext_s;
      retireValid_r   <= retire_s;
      protocolError_r <= protocolError_r | missingData_s;
      if (retire_s) begin
        retiredPc_r <= inProgramCounter;
      end
    end
  end

  assign resultOfInstructionAfterWriteBack = record_r;
  assign retiredProgramCounter             = retiredPc_r;
  assign retireValid                       = retireValid_r;
  assign protocolError                     = protocolError_r;

`ifdef WRITE_BACK_RETIRE_COUNTER_EN
  logic [63:0] retireCount_r;
  logic [63:0] bubbleCount_r;

  // Free-running event counters, wrapping modulo 2^64.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      retireCount_r <= 64'd0;
      bubbleCount_r <= 64'd0;
    end else if (retire_s) begin
      retireCount_r <= retireCount_r + 64'd1;
    end else begin
      bubbleCount_r <= bubbleCount_r + 64'd1;
    end
  end

  assign retireCount = retireCount_r;
  assign bubbleCount = bubbleCount_r;
`endif

endmodule

// File: tb/tb_pipeline_stage_write_back.sv
// Scoreboard bench for pipeline_stage_write_back: directed scenarios plus random traffic
// checked against an array-based reference model. Counters checked when WRITE_BACK_RETIRE_COUNTER_EN.
module tb_pipeline_stage_write_back;
  import pipeline_stage_write_back_pkg::*;

  logic                 clock;
  logic                 reset;
  logic                 inBubble;
  logic [31:0]          inProgramCounter;
  logic                 inRegWriteEnabled;
  logic [4:0]           inRegWriteId;
  logic                 inRegDataWriteReady;
  logic [31:0]          inRegDataWrite;
  logic [4:0]           readId1;
  logic [4:0]           readId2;
  logic [31:0]          readData1;
  logic [31:0]          readData2;
  stage_register_data_t resultOfInstructionAfterWriteBack;
  logic [31:0]          retiredProgramCounter;
  logic                 retireValid;
  logic                 protocolError;
`ifdef WRITE_BACK_RETIRE_COUNTER_EN
  logic [63:0]          retireCount;
  logic [63:0]          bubbleCount;
`endif

  pipeline_stage_write_back dut (
    .clock                             (clock),
    .reset                             (reset),
    .inBubble                          (inBubble),
    .inProgramCounter                  (inProgramCounter),
    .inRegWriteEnabled                 (inRegWriteEnabled),
    .inRegWriteId                      (inRegWriteId),
    .inRegDataWriteReady               (inRegDataWriteReady),
    .inRegDataWrite                    (inRegDataWrite),
    .readId1                           (readId1),
    .readId2                           (readId2),
    .readData1                         (readData1),
    .readData2                         (readData2),
    .resultOfInstructionAfterWriteBack (resultOfInstructionAfterWriteBack),
    .retiredProgramCounter             (retiredProgramCounter),
    .retireValid                       (retireValid),
    .protocolError                     (protocolError)
`ifdef WRITE_BACK_RETIRE_COUNTER_EN
    ,
    .retireCount                       (retireCount),
    .bubbleCount                       (bubbleCount)
`endif
  );

  typedef struct {
    logic        rv;
    logic [31:0] pc;
    logic [4:0]  id;
    logic [31:0] data;
    logic        err;
    logic [63:0] rc;
    logic [63:0] bc;
  } exp_t;

  exp_t        expQ[$];
  int          checks = 0;
  int          errors = 0;

  // Reference model: architectural state as plain variables.
  logic [31:0] modelRegs [32];
  logic [31:0] modelPc;
  logic        modelErr;
  logic [63:0] modelRetires;
  logic [63:0] modelBubbles;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic clearModel();
    for (int i = 0; i < 32; i++) modelRegs[i] = 32'd0;
    modelPc      = 32'd0;
    modelErr     = 1'b0;
    modelRetires = 64'd0;
    modelBubbles = 64'd0;
  endtask

  // One input cycle: drive, check combinational reads, update model, queue expected outputs.
  task automatic drive(input logic b, input logic [31:0] pc, input logic we, input logic [4:0] id,
                       input logic rdy, input logic [31:0] d, input logic [4:0] r1, input logic [4:0] r2);
    exp_t        e;
    logic        wc;
    logic [31:0] x1;
    logic [31:0] x2;
    @(negedge clock);
    inBubble            = b;
    inProgramCounter    = pc;
    inRegWriteEnabled   = we;
    inRegWriteId        = id;
    inRegDataWriteReady = rdy;
    inRegDataWrite      = d;
    readId1             = r1;
    readId2             = r2;
    wc = !b && we && (id != 5'd0) && rdy;
    #1;
    x1 = (r1 == 5'd0) ? 32'd0 : ((wc && r1 == id) ? d : modelRegs[r1]);
    x2 = (r2 == 5'd0) ? 32'd0 : ((wc && r2 == id) ? d : modelRegs[r2]);
    check("readData1", {32'd0, readData1}, {32'd0, x1});
    check("readData2", {32'd0, readData2}, {32'd0, x2});
    if (!b) begin
      modelRetires = modelRetires + 64'd1;
      modelPc      = pc;
      if (we && id != 5'd0) begin
        if (rdy) modelRegs[id] = d;
        else     modelErr = 1'b1;
      end
    end else begin
      modelBubbles = modelBubbles + 64'd1;
    end
    e.rv   = !b;
    e.pc   = modelPc;
    e.id   = wc ? id : 5'd0;
    e.data = wc ? d : 32'd0;
    e.err  = modelErr;
    e.rc   = modelRetires;
    e.bc   = modelBubbles;
    expQ.push_back(e);
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    drive(1'b1, 32'd0, 1'b0, 5'd0, 1'b1, 32'd0, r1, r2);
  endtask

  // Assert reset between edges and confirm everything reads zero without a clock edge.
  task automatic asyncResetCheck();
    @(posedge clock);
    #3;
    inBubble          = 1'b1;
    inRegWriteEnabled = 1'b0;
    reset             = 1'b1;
    #1;
    check("reset retireValid", {63'd0, retireValid}, 64'd0);
    check("reset retiredPc", {32'd0, retiredProgramCounter}, 64'd0);
    check("reset record", {23'd0, resultOfInstructionAfterWriteBack}, {23'd0, 5'd0, 1'b1, 32'd0});
    check("reset protocolError", {63'd0, protocolError}, 64'd0);
`ifdef WRITE_BACK_RETIRE_COUNTER_EN
    check("reset retireCount", retireCount, 64'd0);
    check("reset bubbleCount", bubbleCount, 64'd0);
`endif
    for (int i = 0; i < 32; i += 3) begin
      readId1 = 5'(i);
      readId2 = 5'(31 - i);
      #1;
      check("reset readData1", {32'd0, readData1}, 64'd0);
      check("reset readData2", {32'd0, readData2}, 64'd0);
    end
    clearModel();
    expQ.delete();
    @(posedge clock);
    #3;
    reset = 1'b0;
  endtask

  // Monitor: one output set per clock edge, compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (!reset && expQ.size() > 0) begin
        e = expQ.pop_front();
        check("retireValid", {63'd0, retireValid}, {63'd0, e.rv});
        check("retiredPc", {32'd0, retiredProgramCounter}, {32'd0, e.pc});
        check("record.registerId", {59'd0, resultOfInstructionAfterWriteBack.registerId}, {59'd0, e.id});
        check("record.dataReady", {63'd0, resultOfInstructionAfterWriteBack.dataReady}, 64'd1);
        check("record.data", {32'd0, resultOfInstructionAfterWriteBack.data}, {32'd0, e.data});
        check("protocolError", {63'd0, protocolError}, {63'd0, e.err});
`ifdef WRITE_BACK_RETIRE_COUNTER_EN
        check("retireCount", retireCount, e.rc);
        check("bubbleCount", bubbleCount, e.bc);
`endif
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        b, we, rdy;
    logic [4:0]  id, r1, r2;
    logic [31:0] d;
    reset               = 1'b1;
    inBubble            = 1'b1;
    inProgramCounter    = 32'd0;
    inRegWriteEnabled   = 1'b0;
    inRegWriteId        = 5'd0;
    inRegDataWriteReady = 1'b1;
    inRegDataWrite      = 32'd0;
    readId1             = 5'd0;
    readId2             = 5'd0;
    clearModel();
    asyncResetCheck();

    // r5 write, then read back and observe the one-cycle retire pulse.
    drive(1'b0, 32'h0000_0040, 1'b1, 5'd5, 1'b1, 32'h0000_1234, 5'd1, 5'd2);
    idle(5'd5, 5'd0);
    idle(5'd5, 5'd5);

    // Same-cycle bypass on both ports.
    drive(1'b0, 32'h0000_0044, 1'b1, 5'd7, 1'b1, 32'h0000_DEAD, 5'd7, 5'd7);
    idle(5'd7, 5'd5);

    // r0 write is ignored and raises no error.
    drive(1'b0, 32'h0000_0048, 1'b1, 5'd0, 1'b1, 32'hFFFF_FFFF, 5'd0, 5'd0);
    idle(5'd0, 5'd0);

    // Missing write data sets the sticky error; it survives further clean retires.
    drive(1'b0, 32'h0000_0050, 1'b1, 5'd3, 1'b0, 32'hBAD0_0003, 5'd3, 5'd3);
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 32'h0000_0054 + 32'(4 * i), 1'b1, 5'(10 + i), 1'b1, $urandom, 5'd3, 5'(10 + i));
    end
    idle(5'd3, 5'd12);

    // Retire, bubble, retire from a clean reset.
    asyncResetCheck();
    drive(1'b0, 32'h0000_0100, 1'b0, 5'd0, 1'b1, 32'd0, 5'd0, 5'd0);
    drive(1'b1, 32'h0000_0200, 1'b0, 5'd0, 1'b1, 32'd0, 5'd0, 5'd0);
    drive(1'b0, 32'h0000_0104, 1'b0, 5'd0, 1'b1, 32'd0, 5'd0, 5'd0);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      b   = ($urandom_range(0, 3) == 0);
      we  = ($urandom_range(0, 3) != 0);
      id  = 5'($urandom_range(0, 31));
      rdy = ($urandom_range(0, 15) != 0);
      d   = $urandom;
      r1  = ($urandom_range(0, 3) == 0) ? id : 5'($urandom_range(0, 31));
      r2  = ($urandom_range(0, 3) == 0) ? id : 5'($urandom_range(0, 31));
      drive(b, $urandom, we, id, rdy, d, r1, r2);
    end

    // Several writes, then an asynchronous reset mid-cycle.
    for (int i = 1; i < 6; i++) begin
      drive(1'b0, 32'(i), 1'b1, 5'(i), 1'b1, 32'hA5A5_0000 + 32'(i), 5'(i), 5'd0);
    end
    asyncResetCheck();
    idle(5'd1, 5'd2);

    repeat (3) @(posedge clock);
    #2;
    check("scoreboard drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
